stk_pipe_lk_ctx: RTL and testbench

Parametrised lookup stage for the multi-context linked-list stack engine. Holds per-engine head pointer, occupancy count and pop-pending state, decodes PUSH/POP/INV commands, and issues registered NEXT/DATA SRAM requests toward the MEM stage. Sits between command arbitration and MEM/WRBK; WRBK returns the post-pop head pointer read from NEXT SRAM. Beyond a plain lookup stage, it adds capacity limits, per-context status responses, pointer return to the free list, and a same-context hazard stall.

---
 rtl/stk_pipe_lk_ctx.sv | 223 ++++++++++++++++++++++
 tb/tb_stk_pipe_lk_ctx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stk_pipe_lk_ctx.sv
// -----------------------------------------------------------------------------
// stk_pipe_lk_ctx
//
// Lookup stage of the multi-context linked-list stack engine. Each engine
// context keeps a head pointer, an occupancy count and a pop-pending flag.
// This stage decodes PUSH / POP / INV commands and issues registered NEXT and
// DATA SRAM requests to the MEM stage. WRBK later returns the post-pop head
// pointer that was read from NEXT SRAM.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   i_cmd_*  / o_cmd_rdy   command channel (engid, opcode, push data)
//   i_alloc_* / o_alloc_ack free-list pointer supply; ack is combinational
//   i_wrbk_*               new head pointer after a pop, from WRBK
//   o_nxt_*                NEXT SRAM request (registered)
//   o_dat_*                DATA SRAM request (registered)
//   o_free_*               popped pointer returned to the free list (registered)
//   o_rsp_*                per-command status and post-operation count (registered)
// -----------------------------------------------------------------------------
module stk_pipe_lk_ctx #(
  parameter int ENGS_N  = 4,
  parameter int PTR_W   = 8,
  parameter int DAT_W   = 128,
  parameter int CAP     = 64,
  parameter int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
  parameter int CNT_W   = $clog2(CAP + 1)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               i_cmd_vld,
  output logic               o_cmd_rdy,
  input  logic [ENGID_W-1:0] i_cmd_engid,
  input  logic [1:0]         i_cmd_opcode,
  input  logic [DAT_W-1:0]   i_cmd_dat,
  input  logic               i_alloc_vld,
  input  logic [PTR_W-1:0]   i_alloc_ptr,
  output logic               o_alloc_ack,
  input  logic               i_wrbk_vld,
  input  logic [ENGID_W-1:0] i_wrbk_engid,
  input  logic [PTR_W-1:0]   i_wrbk_head_ptr,
  output logic               o_nxt_ce,
  output logic               o_nxt_we,
  output logic [PTR_W-1:0]   o_nxt_addr,
  output logic [PTR_W-1:0]   o_nxt_din,
  output logic               o_dat_ce,
  output logic               o_dat_we,
  output logic [PTR_W-1:0]   o_dat_addr,
  output logic [DAT_W-1:0]   o_dat_din,
  output logic               o_free_vld,
  output logic [PTR_W-1:0]   o_free_ptr,
  output logic               o_rsp_vld,
  output logic [ENGID_W-1:0] o_rsp_engid,
  output logic [1:0]         o_rsp_status,
  output logic [CNT_W-1:0]   o_rsp_cnt
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_INV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RSP_OK    = 2'b00,
    RSP_EMPTY = 2'b01,
    RSP_FULL  = 2'b10
  } rsp_e;

  // Everything presented to MEM and to the response channel, registered as one.
  typedef struct packed {
    logic               nxt_ce;
    logic               nxt_we;
    logic [PTR_W-1:0]   nxt_addr;
    logic [PTR_W-1:0]   nxt_din;
    logic               dat_ce;
    logic               dat_we;
    logic [PTR_W-1:0]   dat_addr;
    logic [DAT_W-1:0]   dat_din;
    logic               free_vld;
    logic [PTR_W-1:0]   free_ptr;
    logic               rsp_vld;
    logic [ENGID_W-1:0] rsp_engid;
    rsp_e               rsp_status;
    logic [CNT_W-1:0]   rsp_cnt;
  } out_t;

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [PTR_W-1:0]  head_q [ENGS_N];
  logic [CNT_W-1:0]  cnt_q  [ENGS_N];
  logic [ENGS_N-1:0] pend_q;

  op_e              op;
  logic [PTR_W-1:0] cur_head;
  logic [CNT_W-1:0] cur_cnt;
  logic             cur_pend;
  logic             not_full;
  logic             not_empty;
  logic             acc;
  logic             do_push;
  logic             do_pop;
  logic             wrbk_hit;
  out_t             out_d;
  out_t             out_q;

  assign op        = op_e'(i_cmd_opcode);
  assign cur_head  = head_q[i_cmd_engid];
  assign cur_cnt   = cnt_q[i_cmd_engid];
  assign cur_pend  = pend_q[i_cmd_engid];
  assign not_full  = cur_cnt < CAP_C;
  assign not_empty = cur_cnt != '0;

  // A PUSH that would allocate waits for a free pointer; a full-context PUSH
  // needs none and is answered FULL. Held low while reset is asserted.
  assign o_cmd_rdy = arst_n & ~cur_pend & ~((op == OP_PUSH) & not_full & ~i_alloc_vld);

  assign acc         = i_cmd_vld & o_cmd_rdy;
  assign do_push     = acc & (op == OP_PUSH) & not_full;
  assign do_pop      = acc & (op == OP_POP) & not_empty;
  assign o_alloc_ack = do_push;

  // A WRBK only counts for a context that is waiting for one. A command and
  // the WRBK can never target the same context here: the command needs pend
  // clear, the WRBK needs it set.
  assign wrbk_hit = i_wrbk_vld & pend_q[i_wrbk_engid];

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    out_d = '0;
    if (acc && op != OP_NOP) begin
      out_d.rsp_vld   = 1'b1;
      out_d.rsp_engid = i_cmd_engid;
      out_d.rsp_status = RSP_OK;
      unique case (op)
        OP_PUSH: begin
          if (not_full) begin
            out_d.nxt_ce   = 1'b1;
            out_d.nxt_we   = 1'b1;
            out_d.nxt_addr = i_alloc_ptr;
            out_d.nxt_din  = cur_head;   // meaningless when the context is empty
            out_d.dat_ce   = 1'b1;
            out_d.dat_we   = 1'b1;
            out_d.dat_addr = i_alloc_ptr;
            out_d.dat_din  = i_cmd_dat;
            out_d.rsp_cnt  = cur_cnt + ONE_C;
          end else begin
            out_d.rsp_status = RSP_FULL;
            out_d.rsp_cnt    = cur_cnt;
          end
        end
        OP_POP: begin
          if (not_empty) begin
            out_d.nxt_ce   = 1'b1;
            out_d.nxt_addr = cur_head;
            out_d.dat_ce   = 1'b1;
            out_d.dat_addr = cur_head;
            out_d.free_vld = 1'b1;
            out_d.free_ptr = cur_head;
            out_d.rsp_cnt  = cur_cnt - ONE_C;
          end else begin
            out_d.rsp_status = RSP_EMPTY;
          end
        end
        default: ;                       // INV answers OK with count 0
      endcase
    end
  end

  // NOTE: the per-context arrays are small register files, not SRAM, so they
  // are reset with everything else; an empty context must not see stale state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int e = 0; e < ENGS_N; e++) begin
        head_q[e] <= '0;
        cnt_q[e]  <= '0;
      end
      pend_q <= '0;
    end else begin
      if (wrbk_hit) begin
        head_q[i_wrbk_engid] <= i_wrbk_head_ptr;
        pend_q[i_wrbk_engid] <= 1'b0;
      end
      if (do_push) begin
        head_q[i_cmd_engid] <= i_alloc_ptr;
        cnt_q[i_cmd_engid]  <= cur_cnt + ONE_C;
      end
      if (do_pop) begin
        cnt_q[i_cmd_engid] <= cur_cnt - ONE_C;
        // The new head arrives through WRBK only if something is left.
        if (cur_cnt != ONE_C) pend_q[i_cmd_engid] <= 1'b1;
      end
      if (acc && op == OP_INV) begin
        head_q[i_cmd_engid] <= '0;
        cnt_q[i_cmd_engid]  <= '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) out_q <= '0;
    else         out_q <= out_d;
  end

  assign o_nxt_ce     = out_q.nxt_ce;
  assign o_nxt_we     = out_q.nxt_we;
  assign o_nxt_addr   = out_q.nxt_addr;
  assign o_nxt_din    = out_q.nxt_din;
  assign o_dat_ce     = out_q.dat_ce;
  assign o_dat_we     = out_q.dat_we;
  assign o_dat_addr   = out_q.dat_addr;
  assign o_dat_din    = out_q.dat_din;
  assign o_free_vld   = out_q.free_vld;
  assign o_free_ptr   = out_q.free_ptr;
  assign o_rsp_vld    = out_q.rsp_vld;
  assign o_rsp_engid  = out_q.rsp_engid;
  assign o_rsp_status = out_q.rsp_status;
  assign o_rsp_cnt    = out_q.rsp_cnt;

endmodule

// File: tb/tb_stk_pipe_lk_ctx.sv
// -----------------------------------------------------------------------------
// tb_stk_pipe_lk_ctx
//
// Directed scenarios followed by randomized traffic against a reference model
// that keeps every context as a stack of line pointers. The bench also plays
// the WRBK stage: a pending context is released with the pointer now on top
// of its stack. Inputs change on the falling edge; registered outputs are
// compared on the following falling edge, combinational ones 1 ns after drive.
// -----------------------------------------------------------------------------
module tb_stk_pipe_lk_ctx;

  localparam int ENGS_N  = 4;
  localparam int PTR_W   = 8;
  localparam int DAT_W   = 32;
  localparam int CAP     = 2;
  localparam int ENGID_W = 2;
  localparam int CNT_W   = 2;

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, INV = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_EMPTY = 2'b01, ST_FULL = 2'b10;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               i_cmd_vld;
  logic               o_cmd_rdy;
  logic [ENGID_W-1:0] i_cmd_engid;
  logic [1:0]         i_cmd_opcode;
  logic [DAT_W-1:0]   i_cmd_dat;
  logic               i_alloc_vld;
  logic [PTR_W-1:0]   i_alloc_ptr;
  logic               o_alloc_ack;
  logic               i_wrbk_vld;
  logic [ENGID_W-1:0] i_wrbk_engid;
  logic [PTR_W-1:0]   i_wrbk_head_ptr;
  logic               o_nxt_ce, o_nxt_we, o_dat_ce, o_dat_we, o_free_vld, o_rsp_vld;
  logic [PTR_W-1:0]   o_nxt_addr, o_nxt_din, o_dat_addr, o_free_ptr;
  logic [DAT_W-1:0]   o_dat_din;
  logic [ENGID_W-1:0] o_rsp_engid;
  logic [1:0]         o_rsp_status;
  logic [CNT_W-1:0]   o_rsp_cnt;

  always #5 clk = ~clk;

  stk_pipe_lk_ctx #(
    .ENGS_N(ENGS_N), .PTR_W(PTR_W), .DAT_W(DAT_W), .CAP(CAP)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy), .i_cmd_engid(i_cmd_engid),
    .i_cmd_opcode(i_cmd_opcode), .i_cmd_dat(i_cmd_dat),
    .i_alloc_vld(i_alloc_vld), .i_alloc_ptr(i_alloc_ptr), .o_alloc_ack(o_alloc_ack),
    .i_wrbk_vld(i_wrbk_vld), .i_wrbk_engid(i_wrbk_engid), .i_wrbk_head_ptr(i_wrbk_head_ptr),
    .o_nxt_ce(o_nxt_ce), .o_nxt_we(o_nxt_we), .o_nxt_addr(o_nxt_addr), .o_nxt_din(o_nxt_din),
    .o_dat_ce(o_dat_ce), .o_dat_we(o_dat_we), .o_dat_addr(o_dat_addr), .o_dat_din(o_dat_din),
    .o_free_vld(o_free_vld), .o_free_ptr(o_free_ptr),
    .o_rsp_vld(o_rsp_vld), .o_rsp_engid(o_rsp_engid), .o_rsp_status(o_rsp_status),
    .o_rsp_cnt(o_rsp_cnt)
  );

  // Expected registered outputs for the command accepted in the previous cycle.
  typedef struct packed {
    logic             nxt_ce, nxt_we, nxt_din_chk;
    logic [PTR_W-1:0] nxt_addr, nxt_din;
    logic             dat_ce, dat_we;
    logic [PTR_W-1:0] dat_addr;
    logic [DAT_W-1:0] dat_din;
    logic             free_vld;
    logic [PTR_W-1:0] free_ptr;
    logic             rsp_vld;
    logic [1:0]       rsp_eng, rsp_status;
    logic [CNT_W-1:0] rsp_cnt;
  } exp_t;

  logic [PTR_W-1:0] stk [ENGS_N][$];   // per-context stack, top at the back
  bit               pend_m [ENGS_N];
  exp_t             ex;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < ENGS_N; e++) begin
      stk[e].delete();
      pend_m[e] = 1'b0;
    end
    ex = '0;
  endtask

  task automatic check_regs();
    check("nxt_ce", o_nxt_ce, ex.nxt_ce);
    check("nxt_we", o_nxt_we, ex.nxt_we);
    if (ex.nxt_ce)      check("nxt_addr", o_nxt_addr, ex.nxt_addr);
    if (ex.nxt_din_chk) check("nxt_din", o_nxt_din, ex.nxt_din);
    check("dat_ce", o_dat_ce, ex.dat_ce);
    check("dat_we", o_dat_we, ex.dat_we);
    if (ex.dat_ce) check("dat_addr", o_dat_addr, ex.dat_addr);
    if (ex.dat_we) check("dat_din", o_dat_din, ex.dat_din);
    check("free_vld", o_free_vld, ex.free_vld);
    if (ex.free_vld) check("free_ptr", o_free_ptr, ex.free_ptr);
    check("rsp_vld", o_rsp_vld, ex.rsp_vld);
    if (ex.rsp_vld) begin
      check("rsp_engid", o_rsp_engid, ex.rsp_eng);
      check("rsp_status", o_rsp_status, ex.rsp_status);
      check("rsp_cnt", o_rsp_cnt, ex.rsp_cnt);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, o_cmd_rdy, 0);
    check({tag, "_outs"},
          {o_nxt_ce, o_nxt_we, o_nxt_addr, o_nxt_din, o_dat_ce, o_dat_we, o_dat_addr,
           o_free_vld, o_free_ptr, o_rsp_vld, o_rsp_engid, o_rsp_status, o_rsp_cnt}, 0);
    check({tag, "_dat_din"}, o_dat_din, 0);
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic cycle(input bit vld, input int eng, input logic [1:0] op,
                       input logic [DAT_W-1:0] dat, input bit avld,
                       input logic [PTR_W-1:0] aptr, input bit wvld, input int weng,
                       input logic [PTR_W-1:0] wptr);
    int   size;
    bit   exp_rdy, acc, wrbk_hit;
    exp_t nx;
    check_regs();
    i_cmd_vld       = vld;
    i_cmd_engid     = ENGID_W'(eng);
    i_cmd_opcode    = op;
    i_cmd_dat       = dat;
    i_alloc_vld     = avld;
    i_alloc_ptr     = aptr;
    i_wrbk_vld      = wvld;
    i_wrbk_engid    = ENGID_W'(weng);
    i_wrbk_head_ptr = wptr;
    #1;
    size    = stk[eng].size();
    exp_rdy = !pend_m[eng] && !(op == PUSH && size < CAP && !avld);
    check("cmd_rdy", o_cmd_rdy, exp_rdy);
    acc = vld && exp_rdy;
    check("alloc_ack", o_alloc_ack, acc && op == PUSH && size < CAP);
    wrbk_hit = wvld && pend_m[weng];
    nx = '0;
    if (acc && op != NOP) begin
      nx.rsp_vld = 1'b1;
      nx.rsp_eng = 2'(eng);
      nx.rsp_status = ST_OK;
      case (op)
        PUSH: if (size < CAP) begin
          nx.nxt_ce = 1'b1; nx.nxt_we = 1'b1; nx.nxt_addr = aptr;
          nx.nxt_din_chk = size > 0;
          if (size > 0) nx.nxt_din = stk[eng][$];
          nx.dat_ce = 1'b1; nx.dat_we = 1'b1; nx.dat_addr = aptr; nx.dat_din = dat;
          stk[eng].push_back(aptr);
          nx.rsp_cnt = CNT_W'(size + 1);
        end else begin
          nx.rsp_status = ST_FULL;
          nx.rsp_cnt = CNT_W'(size);
        end
        POP: if (size > 0) begin
          nx.nxt_ce = 1'b1; nx.nxt_addr = stk[eng][$];
          nx.dat_ce = 1'b1; nx.dat_addr = stk[eng][$];
          nx.free_vld = 1'b1; nx.free_ptr = stk[eng][$];
          void'(stk[eng].pop_back());
          nx.rsp_cnt = CNT_W'(size - 1);
          pend_m[eng] = (size - 1) > 0;
        end else begin
          nx.rsp_status = ST_EMPTY;
        end
        default: stk[eng].delete();
      endcase
    end
    if (wrbk_hit) pend_m[weng] = 1'b0;
    ex = nx;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, NOP, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    i_cmd_vld = 1'b1; i_cmd_opcode = PUSH; i_alloc_vld = 1'b1;
    arst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    i_cmd_vld = 1'b0; i_alloc_vld = 1'b0; i_wrbk_vld = 1'b0;
    arst_n = 1'b1;
  endtask

  initial begin
    int eng, weng;
    bit wvld;
    logic [1:0] op;
    logic [PTR_W-1:0] wptr;

    arst_n = 1'b0;
    i_cmd_vld = 1'b0; i_cmd_engid = '0; i_cmd_opcode = NOP; i_cmd_dat = '0;
    i_alloc_vld = 1'b0; i_alloc_ptr = '0;
    i_wrbk_vld = 1'b0; i_wrbk_engid = '0; i_wrbk_head_ptr = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    arst_n = 1'b1;

    // POP on an empty context.
    cycle(1, 0, POP, '0, 0, '0, 0, 0, '0);
    check("pop_empty_status", o_rsp_status, ST_EMPTY);

    // Two pushes link 0x09 -> 0x05.
    cycle(1, 1, PUSH, 32'hA0A0_0001, 1, 8'h05, 0, 0, '0);
    check("push1_cnt", o_rsp_cnt, 1);
    cycle(1, 1, PUSH, 32'hB0B0_0002, 1, 8'h09, 0, 0, '0);
    check("push2_nxt_din", o_nxt_din, 8'h05);
    check("push2_cnt", o_rsp_cnt, 2);

    // POP leaves one entry: blocked until the cycle after WRBK.
    cycle(1, 1, POP, '0, 0, '0, 0, 0, '0);
    check("pop_addr", o_nxt_addr, 8'h09);
    check("pop_free", o_free_ptr, 8'h09);
    cycle(1, 1, POP, '0, 0, '0, 1, 1, 8'h05);
    check("blocked_no_rsp", o_rsp_vld, 0);
    cycle(1, 1, POP, '0, 0, '0, 0, 0, '0);
    check("pop_last_addr", o_dat_addr, 8'h05);
    check("pop_last_cnt", o_rsp_cnt, 0);

    // Capacity limit.
    cycle(1, 2, PUSH, 32'h1, 1, 8'h10, 0, 0, '0);
    cycle(1, 2, PUSH, 32'h2, 1, 8'h11, 0, 0, '0);
    cycle(1, 2, PUSH, 32'h3, 1, 8'h12, 0, 0, '0);
    check("full_status", o_rsp_status, ST_FULL);
    check("full_no_ce", o_nxt_ce | o_dat_ce, 0);

    // PUSH waits for a free pointer.
    cycle(1, 0, PUSH, 32'h4, 0, 8'h00, 0, 0, '0);
    cycle(1, 0, PUSH, 32'h4, 0, 8'h00, 0, 0, '0);
    cycle(1, 0, PUSH, 32'h4, 1, 8'h20, 0, 0, '0);
    check("late_alloc_addr", o_dat_addr, 8'h20);

    // Other contexts proceed while one is pending; WRBK and command together.
    cycle(1, 1, PUSH, 32'h5, 1, 8'h30, 0, 0, '0);
    cycle(1, 1, PUSH, 32'h6, 1, 8'h31, 0, 0, '0);
    cycle(1, 1, POP, '0, 0, '0, 0, 0, '0);
    cycle(1, 3, PUSH, 32'h7, 1, 8'h40, 1, 1, 8'h30);
    check("ctx3_while_pend", o_rsp_engid, 3);
    cycle(1, 1, PUSH, 32'h8, 1, 8'h32, 0, 0, '0);
    check("push_after_wrbk_din", o_nxt_din, 8'h30);

    // INV then POP.
    cycle(1, 1, INV, '0, 0, '0, 0, 0, '0);
    check("inv_cnt", o_rsp_cnt, 0);
    cycle(1, 1, POP, '0, 0, '0, 0, 0, '0);
    check("pop_after_inv", o_rsp_status, ST_EMPTY);

    do_reset();
    cycle(1, 2, POP, '0, 0, '0, 0, 0, '0);
    check("pop_after_reset", o_rsp_status, ST_EMPTY);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      eng  = $urandom_range(0, ENGS_N - 1);
      op   = 2'($urandom_range(0, 3));
      weng = $urandom_range(0, ENGS_N - 1);
      wvld = 1'b0;
      wptr = '0;
      if (pend_m[weng] && ($urandom % 3 != 0)) begin
        wvld = 1'b1;
        wptr = stk[weng][$];
      end else if (!pend_m[weng] && ($urandom % 16 == 0)) begin
        wvld = 1'b1;
        wptr = 8'($urandom);
      end
      cycle(($urandom % 4) != 0, eng, op, $urandom, ($urandom % 4) != 0, 8'($urandom),
            wvld, weng, wptr);
    end
    idle();
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
